audio_rec_play_ctrl: RTL and testbench
======================================

Name: audio_rec_play_ctrl

Overview:
Record/playback sequencer for the WM8978 audio path. In record it stores each received stereo sample (adc_data on rx_done) into a single-port sample RAM. In play it streams the stored samples back to dac_data, paced by tx_done. It sits between the codec controller and an on-chip sample RAM, driven by debounced user keys.

Parameters:
ADDR_W, 14, sample RAM address width; depth = 2^ADDR_W stereo words
DW, 32, sample word width ({left16, right16})

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rec_key  in  1  one-cycle pulse (debounced, clk domain): start recording
play_key  in  1  one-cycle pulse: start playback
stop_key  in  1  one-cycle pulse: abort record/play
rx_done  in  1  codec-side receive strobe (aud_bclk domain, asynchronous to clk)
tx_done  in  1  codec-side transmit strobe (aud_bclk domain, asynchronous to clk)
adc_data  in  DW  received sample; held stable for a full frame after rx_done
dac_data  out  DW  sample to transmit
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address (shared by read and write)
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data; 1-cycle latency after address
state  out  2  0=IDLE, 1=REC, 2=PLAY
rec_len  out  ADDR_W+1  number of valid recorded samples

Behaviour:
- Reset (async, rst=1): state=IDLE; dac_data=0; ram_we=0; ram_addr=0; ram_wdata=0; rec_len=0; synchronisers cleared.
- CDC: rx_done and tx_done each pass through a 2-flop synchroniser plus a rising-edge detector, giving rx_p/tx_p. A one-cycle pulse occurs on the 3rd clk edge after the strobe rises. One pulse per strobe, regardless of strobe width.
- Key priority in any cycle: stop > rec > play. rec_key/play_key are honoured only in IDLE.
- IDLE:
  - rec_key -> REC; wr_cnt=0; rec_len=0.
  - play_key with rec_len>0 -> PLAY; rd_cnt=0; ram_addr=0 (prefetch).
  - play_key with rec_len=0 is ignored.
  - dac_data=0.
- REC:
  - On rx_p: ram_we=1 for exactly that cycle; ram_addr=wr_cnt; ram_wdata=adc_data; wr_cnt++.
  - rec_len tracks wr_cnt after each write.
  - After write number 2^ADDR_W (RAM full): -> IDLE next cycle; rec_len=2^ADDR_W. No wrap-around and no overwrite.
  - stop_key -> IDLE; rec_len keeps the samples written so far. A stop coinciding with rx_p still performs that write first.
- PLAY:
  - ram_addr holds rd_cnt; prefetched word is ram_rdata.
  - On tx_p: dac_data<=ram_rdata (the word at rd_cnt); rd_cnt++; ram_addr<=rd_cnt+1.
  - After the rec_len-th tx_p: -> IDLE. dac_data holds the last sample for that frame and goes to 0 on the following tx_p seen in IDLE.
  - stop_key -> IDLE; dac_data=0 immediately.
  - ram_we is always 0 in PLAY.
- Ordering constraint: tx_p and rx_p are at least 2 clk apart (frame rate << clk), so the 1-cycle RAM latency is always met.
- Keys during reset are ignored. Reset mid-REC discards rec_len (returns to 0).

Decomposition:
- Shared package (audio_pkg): state encodings ST_IDLE/ST_REC/ST_PLAY, DW default, sample-format constant.
- One sub-module: pulse_sync (2-flop synchroniser + rising-edge detect), instanced twice (rx_done, tx_done).
- Sample RAM is external to this block.

Test Plan:
- Reset then rec_key; 5 rx_done strobes with adc_data=32'h0001_0001..32'h0005_0005 -> 5 ram_we pulses, each 3 clk after its strobe; addr 0..4 hold those words; stop_key -> state=IDLE, rec_len=5.
- play_key after above; 6 tx_done strobes -> dac_data = 0001_0001..0005_0005 on strobes 1-5, state=IDLE after strobe 5, dac_data=0 after strobe 6.
- play_key with rec_len=0 -> state stays IDLE, no RAM activity.
- ADDR_W=3, rec_key, 10 rx_done strobes -> exactly 8 writes, addr 0..7, state=IDLE after 8th, rec_len=8.
- rec_key and play_key in the same cycle in IDLE -> REC. stop_key and rec_key in the same cycle -> stays IDLE.
- Mid-PLAY stop_key -> dac_data=0 the next cycle. Assert rst mid-REC -> all outputs to reset values asynchronously; rec_len=0.

Source files
------------

// File: rtl/audio_rec_play_ctrl_pkg.sv
// Shared types and defaults for the audio record/playback sequencer.
// A sample word is {left, right}, each channel CH_W bits wide.
package audio_rec_play_ctrl_pkg;

    localparam int CH_W       = 16;
    localparam int DEF_DW     = 2 * CH_W;
    localparam int DEF_ADDR_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/audio_rec_play_ctrl_if.sv
// Codec strobe/data and sample-RAM bus seen by the record/playback sequencer.
interface audio_rec_play_ctrl_if
    import audio_rec_play_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DW     = DEF_DW
);
    logic              rx_done;
    logic              tx_done;
    logic [DW-1:0]     adc_data;
    logic [DW-1:0]     dac_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;

    modport master (
        input  rx_done, tx_done, adc_data, ram_rdata,
        output dac_data, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output rx_done, tx_done, adc_data, ram_rdata,
        input  dac_data, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/audio_rec_play_ctrl_pulse_sync.sv
// Brings an asynchronous strobe into the clk domain and emits one pulse per rising edge.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic pulse
);
    // [0],[1] are the metastability pair; [2] is the previous value for edge detect
    logic [2:0] sync_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[1:0], strobe};
    end

    assign pulse = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer: captures codec samples into an external RAM and
// streams them back to the DAC, paced by the codec strobes.
module audio_rec_play_ctrl
    import audio_rec_play_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DW     = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rec_key,
    input  logic                   play_key,
    input  logic                   stop_key,
    audio_rec_play_ctrl_if.master  bus,
    output logic [1:0]             state,
    output logic [ADDR_W:0]        rec_len
);
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic rx_p, tx_p;

    pulse_sync u_rx_sync (.clk(clk), .rst(rst), .strobe(bus.rx_done), .pulse(rx_p));
    pulse_sync u_tx_sync (.clk(clk), .rst(rst), .strobe(bus.tx_done), .pulse(tx_p));

    state_t            st_q, st_d;
    logic [ADDR_W:0]   len_q, len_d;   // doubles as the write counter while recording
    logic [ADDR_W:0]   rd_q, rd_d;
    logic [ADDR_W:0]   rd_nxt;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     dac_q, dac_d;

    assign rd_nxt = rd_q + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            len_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dac_q   <= '0;
        end else begin
            st_q    <= st_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dac_q   <= dac_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                if (stop_key)                            st_d = ST_IDLE;
                else if (rec_key)                        st_d = ST_REC;
                else if (play_key && len_q != '0)        st_d = ST_PLAY;
            end
            ST_REC:
                if (stop_key || (rx_p && len_q == FULL_CNT - ONE)) st_d = ST_IDLE;
            ST_PLAY:
                if (stop_key || (tx_p && rd_nxt == len_q))         st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        rd_d    = rd_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dac_d   = dac_q;
        case (st_q)
            ST_IDLE: begin
                // last played sample stays up for its frame, then silence
                if (tx_p) dac_d = '0;
                if (!stop_key) begin
                    if (rec_key) begin
                        len_d = '0;
                        dac_d = '0;
                    end else if (play_key && len_q != '0) begin
                        rd_d   = '0;
                        addr_d = '0;
                    end
                end
            end
            ST_REC: begin
                // a stop arriving with a sample still commits that sample
                if (rx_p && len_q != FULL_CNT) begin
                    we_d    = 1'b1;
                    addr_d  = len_q[ADDR_W-1:0];
                    wdata_d = bus.adc_data;
                    len_d   = len_q + ONE;
                end
            end
            ST_PLAY: begin
                if (stop_key) begin
                    dac_d = '0;
                end else if (tx_p) begin
                    dac_d  = bus.ram_rdata;
                    rd_d   = rd_nxt;
                    addr_d = rd_nxt[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    assign state         = st_q;
    assign rec_len       = len_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.dac_data  = dac_q;
endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench: a full-size instance (a) and an 8-deep instance (b) share stimulus.
module tb_audio_rec_play_ctrl;
    import audio_rec_play_ctrl_pkg::*;

    localparam int AW_A = 14;
    localparam int AW_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rec_key = 1'b0, play_key = 1'b0, stop_key = 1'b0;
    logic        rx_done = 1'b0, tx_done = 1'b0;
    logic [31:0] adc_data = '0;

    audio_rec_play_ctrl_if #(.ADDR_W(AW_A), .DW(32)) ia ();
    audio_rec_play_ctrl_if #(.ADDR_W(AW_B), .DW(32)) ib ();

    assign ia.rx_done = rx_done;  assign ib.rx_done = rx_done;
    assign ia.tx_done = tx_done;  assign ib.tx_done = tx_done;
    assign ia.adc_data = adc_data; assign ib.adc_data = adc_data;

    logic [1:0]    state_a, state_b;
    logic [AW_A:0] rec_len_a;
    logic [AW_B:0] rec_len_b;

    audio_rec_play_ctrl #(.ADDR_W(AW_A), .DW(32)) dut_a (
        .clk(clk), .rst(rst), .rec_key(rec_key), .play_key(play_key), .stop_key(stop_key),
        .bus(ia), .state(state_a), .rec_len(rec_len_a));

    audio_rec_play_ctrl #(.ADDR_W(AW_B), .DW(32)) dut_b (
        .clk(clk), .rst(rst), .rec_key(rec_key), .play_key(play_key), .stop_key(stop_key),
        .bus(ib), .state(state_b), .rec_len(rec_len_b));

    // single-port RAMs with one cycle of read latency
    logic [31:0] mem_a [2**AW_A];
    logic [31:0] mem_b [2**AW_B];

    always @(posedge clk) begin
        if (ia.ram_we) mem_a[ia.ram_addr] <= ia.ram_wdata;
        ia.ram_rdata <= mem_a[ia.ram_addr];
        if (ib.ram_we) mem_b[ib.ram_addr] <= ib.ram_wdata;
        ib.ram_rdata <= mem_b[ib.ram_addr];
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_state", 64'(state_a), 64'd0);
        chk("rst_dac", 64'(ia.dac_data), 64'd0);
        chk("rst_we", 64'(ia.ram_we), 64'd0);
        chk("rst_addr", 64'(ia.ram_addr), 64'd0);
        chk("rst_wdata", 64'(ia.ram_wdata), 64'd0);
        chk("rst_len", 64'(rec_len_a), 64'd0);
        rst = 1'b0;
        tick(1);

        // record five samples, then stop
        rec_key = 1'b1; tick(1); rec_key = 1'b0;
        chk("rec_enter", 64'(state_a), 64'd1);
        for (int i = 0; i < 5; i++) begin
            adc_data = 32'(i + 1) * 32'h0001_0001;
            rx_done = 1'b1;
            tick(3);
            chk("rec_we", 64'(ia.ram_we), 64'd1);
            chk("rec_addr", 64'(ia.ram_addr), 64'(i));
            chk("rec_wdata", 64'(ia.ram_wdata), 64'(32'(i + 1) * 32'h0001_0001));
            tick(1);
            chk("rec_we_drop", 64'(ia.ram_we), 64'd0);
            chk("rec_len", 64'(rec_len_a), 64'(i + 1));
            rx_done = 1'b0;
            tick(3);
        end
        stop_key = 1'b1; tick(1); stop_key = 1'b0;
        chk("stop_state", 64'(state_a), 64'd0);
        chk("stop_len", 64'(rec_len_a), 64'd5);
        chk("mem0", 64'(mem_a[0]), 64'h0001_0001);
        chk("mem4", 64'(mem_a[4]), 64'h0005_0005);

        // play back five samples plus one trailing frame
        play_key = 1'b1; tick(1); play_key = 1'b0;
        chk("play_enter", 64'(state_a), 64'd2);
        chk("play_addr", 64'(ia.ram_addr), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tx_done = 1'b1;
            tick(3);
            chk("play_dac", 64'(ia.dac_data), (i < 5) ? 64'(32'(i + 1) * 32'h0001_0001) : 64'd0);
            chk("play_state", 64'(state_a), (i < 4) ? 64'd2 : 64'd0);
            chk("play_we", 64'(ia.ram_we), 64'd0);
            tx_done = 1'b0;
            tick(3);
            chk("play_hold", 64'(ia.dac_data), (i < 5) ? 64'(32'(i + 1) * 32'h0001_0001) : 64'd0);
        end

        // empty recording: play is ignored
        rec_key = 1'b1; tick(1); rec_key = 1'b0;
        stop_key = 1'b1; tick(1); stop_key = 1'b0;
        chk("empty_len", 64'(rec_len_a), 64'd0);
        play_key = 1'b1; tick(1); play_key = 1'b0;
        chk("empty_play", 64'(state_a), 64'd0);
        tick(4);
        chk("empty_we", 64'(ia.ram_we), 64'd0);
        chk("empty_addr", 64'(ia.ram_addr), 64'd5);

        // key priority
        rec_key = 1'b1; play_key = 1'b1; tick(1); rec_key = 1'b0; play_key = 1'b0;
        chk("rec_over_play", 64'(state_a), 64'd1);
        stop_key = 1'b1; tick(1); stop_key = 1'b0;
        chk("stop_rec", 64'(state_a), 64'd0);
        stop_key = 1'b1; rec_key = 1'b1; tick(1); stop_key = 1'b0; rec_key = 1'b0;
        chk("stop_over_rec", 64'(state_a), 64'd0);

        // fill the 8-deep instance with ten strobes
        rec_key = 1'b1; tick(1); rec_key = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_data = 32'h0010_0000 + 32'(i);
            rx_done = 1'b1;
            tick(3);
            chk("full_we", 64'(ib.ram_we), (i < 8) ? 64'd1 : 64'd0);
            if (i < 8) chk("full_addr", 64'(ib.ram_addr), 64'(i));
            chk("full_state", 64'(state_b), (i < 7) ? 64'd1 : 64'd0);
            tick(1);
            rx_done = 1'b0;
            tick(3);
        end
        chk("full_len", 64'(rec_len_b), 64'd8);
        chk("full_mem0", 64'(mem_b[0]), 64'h0010_0000);
        chk("full_mem7", 64'(mem_b[7]), 64'h0010_0007);
        chk("big_len", 64'(rec_len_a), 64'd10);

        // stop coinciding with a sample still writes it
        adc_data = 32'hABCD_1234;
        rx_done = 1'b1;
        tick(2);
        stop_key = 1'b1; tick(1); stop_key = 1'b0;
        chk("stopwr_we", 64'(ia.ram_we), 64'd1);
        chk("stopwr_addr", 64'(ia.ram_addr), 64'd10);
        chk("stopwr_state", 64'(state_a), 64'd0);
        chk("stopwr_len", 64'(rec_len_a), 64'd11);
        tick(1);
        rx_done = 1'b0;
        tick(3);

        // stop mid-playback silences the DAC at once
        play_key = 1'b1; tick(1); play_key = 1'b0;
        chk("mid_enter", 64'(state_a), 64'd2);
        tx_done = 1'b1;
        tick(3);
        chk("mid_dac", 64'(ia.dac_data), 64'h0010_0000);
        tx_done = 1'b0;
        tick(3);
        stop_key = 1'b1; tick(1); stop_key = 1'b0;
        chk("mid_stop_dac", 64'(ia.dac_data), 64'd0);
        chk("mid_stop_state", 64'(state_a), 64'd0);

        // asynchronous reset in the middle of a recording
        rec_key = 1'b1; tick(1); rec_key = 1'b0;
        adc_data = 32'h5555_AAAA;
        rx_done = 1'b1;
        tick(3);
        chk("arst_pre_we", 64'(ia.ram_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_state", 64'(state_a), 64'd0);
        chk("arst_we", 64'(ia.ram_we), 64'd0);
        chk("arst_addr", 64'(ia.ram_addr), 64'd0);
        chk("arst_wdata", 64'(ia.ram_wdata), 64'd0);
        chk("arst_len", 64'(rec_len_a), 64'd0);
        chk("arst_len_b", 64'(rec_len_b), 64'd0);
        rx_done = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("post_rst_state", 64'(state_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
